// File: rtl/seq_mult_n_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package mult_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++)
         if ((1 << r) < n) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/seq_mult_n_cond_negate.sv
// Two's-complement negate when en is high, pass-through otherwise.
module cond_negate #(
   parameter int W = 8
) (
   input  logic         en,
   input  logic [W-1:0] x,
   output logic [W-1:0] y
);

   assign y = en ? (~x + 1'b1) : x;

endmodule

// File: rtl/seq_mult_n.sv
// Sequential N-bit multiplier, signed or unsigned per operation, N+1 cycles
// from accepted start to the done pulse.
module seq_mult_n
   import mult_pkg::*;
#(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic           is_signed,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] prod
);

   localparam int CW = clog2(N);

   state_t         state, state_nxt;
   logic [CW-1:0]  cnt;
   logic [2*N-1:0] acc, acc_nxt, prod_fix;
   logic [2*N:0]   full;
   logic [N:0]     upper;
   logic [N-1:0]   ma, mb, ma_in, mb_in;
   logic           neg, last;

   cond_negate #(.W(N))   u_neg_a (.en(is_signed & a[N-1]), .x(a), .y(ma_in));
   cond_negate #(.W(N))   u_neg_b (.en(is_signed & b[N-1]), .x(b), .y(mb_in));
   cond_negate #(.W(2*N)) u_neg_p (.en(neg), .x(acc_nxt), .y(prod_fix));

   // upper[N] is the carry bit of the 2N+1-bit accumulator; after the shift
   // it always lands back inside the 2N stored bits.
   always_comb begin
      upper   = {1'b0, acc[2*N-1:N]} + (mb[0] ? {1'b0, ma} : {(N+1){1'b0}});
      full    = {upper, acc[N-1:0]};
      acc_nxt = (2*N)'(full >> 1);
   end

   assign last = (cnt == CW'(N-1));

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last)  state_nxt = DONE;
         DONE:    state_nxt = start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         acc   <= '0;
         ma    <= '0;
         mb    <= '0;
         neg   <= 1'b0;
         prod  <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  ma  <= ma_in;
                  mb  <= mb_in;
                  neg <= is_signed & (a[N-1] ^ b[N-1]);
                  acc <= '0;
                  cnt <= '0;
               end
            end
            RUN: begin
               acc <= acc_nxt;
               mb  <= mb >> 1;
               cnt <= cnt + 1'b1;
               if (last) prod <= prod_fix;
            end
            default: ;
         endcase
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_seq_mult_n.sv
// Scoreboard bench for seq_mult_n at N=8 (directed), N=4 (exhaustive) and N=16 (random).
module tb_seq_mult_n;

   logic clk = 1'b0, reset = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        s8 = 0, is8 = 0, busy8, done8;
   logic [7:0]  a8 = 0, b8 = 0;
   logic [15:0] prod8;
   logic        s4 = 0, is4 = 0, busy4, done4;
   logic [3:0]  a4 = 0, b4 = 0;
   logic [7:0]  prod4;
   logic        s16 = 0, is16 = 0, busy16, done16;
   logic [15:0] a16 = 0, b16 = 0;
   logic [31:0] prod16;

   seq_mult_n #(.N(8)) dut8 (.clk(clk), .reset(reset), .start(s8), .is_signed(is8),
      .a(a8), .b(b8), .busy(busy8), .done(done8), .prod(prod8));
   seq_mult_n #(.N(4)) dut4 (.clk(clk), .reset(reset), .start(s4), .is_signed(is4),
      .a(a4), .b(b4), .busy(busy4), .done(done4), .prod(prod4));
   seq_mult_n #(.N(16)) dut16 (.clk(clk), .reset(reset), .start(s16), .is_signed(is16),
      .a(a16), .b(b16), .busy(busy16), .done(done16), .prod(prod16));

   typedef struct {longint p; int c;} exp_t;
   exp_t q8[$], q4[$], q16[$];
   int ntests = 0, nfail = 0;

   task automatic chk(string nm, longint act, longint exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic longint refp(int n, longint a, longint b, bit s);
      longint sa, sb, p;
      sa = a; sb = b;
      if (s && a[n-1]) sa = a - (longint'(1) << n);
      if (s && b[n-1]) sb = b - (longint'(1) << n);
      p = sa * sb;
      return p & ((longint'(1) << (2*n)) - 1);
   endfunction

   function automatic logic cur_busy(int k);
      return (k == 0) ? busy8 : (k == 1) ? busy4 : busy16;
   endfunction

   function automatic int qsize(int k);
      return (k == 0) ? q8.size() : (k == 1) ? q4.size() : q16.size();
   endfunction

   task automatic on_done(int k, longint p, logic bz, int n);
      exp_t e;
      bit   ok;
      ok = 0;
      case (k)
         0: if (q8.size()  != 0) begin e = q8.pop_front();  ok = 1; end
         1: if (q4.size()  != 0) begin e = q4.pop_front();  ok = 1; end
         default: if (q16.size() != 0) begin e = q16.pop_front(); ok = 1; end
      endcase
      if (!ok) begin
         ntests++; nfail++;
         $display("FAIL unexpected_done N=%0d: got prod %0h expected no pulse", n, p);
         return;
      end
      chk($sformatf("prod N=%0d", n), p, e.p);
      chk($sformatf("latency N=%0d", n), cyc - e.c, n + 1);
      chk($sformatf("busy_at_done N=%0d", n), bz, 0);
   endtask

   always @(negedge clk) if (done8)  on_done(0, prod8,  busy8,  8);
   always @(negedge clk) if (done4)  on_done(1, prod4,  busy4,  4);
   always @(negedge clk) if (done16) on_done(2, prod16, busy16, 16);

   // Called at a negedge; launches one op and pushes its expected product.
   task automatic issue(int k, longint a, longint b, bit s, longint exp);
      for (int n = 0; n < 100 && cur_busy(k); n++) @(negedge clk);
      if (cur_busy(k)) begin
         ntests++; nfail++;
         $display("FAIL issue_timeout k=%0d: busy stuck 1 expected 0", k);
         return;
      end
      case (k)
         0: begin a8 = a[7:0];   b8 = b[7:0];   is8 = s;  s8 = 1;  q8.push_back('{exp, cyc});  end
         1: begin a4 = a[3:0];   b4 = b[3:0];   is4 = s;  s4 = 1;  q4.push_back('{exp, cyc});  end
         default: begin a16 = a[15:0]; b16 = b[15:0]; is16 = s; s16 = 1; q16.push_back('{exp, cyc}); end
      endcase
      @(negedge clk);
      s8 = 0; s4 = 0; s16 = 0;
   endtask

   task automatic drain(int k);
      for (int n = 0; n < 400 && qsize(k) != 0; n++) @(negedge clk);
      if (qsize(k) != 0) begin
         ntests++; nfail++;
         $display("FAIL drain_timeout k=%0d: %0d pending expected 0", k, qsize(k));
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: sim time %0t expected finish earlier", $time);
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("reset busy", busy8, 0);
      chk("reset done", done8, 0);
      chk("reset prod", prod8, 0);
      reset = 0;
      @(negedge clk);

      issue(0, 13, 11, 0, 143);
      chk("busy_in_run", busy8, 1);
      issue(0, 255, 255, 0, 'hFE01);
      issue(0, 0, 200, 0, 0);
      issue(0, 'hF9, 6, 1, 'hFFD6);
      issue(0, 'h80, 'h80, 1, 'h4000);
      issue(0, 'h80, 127, 1, 'hC080);
      drain(0);
      repeat (3) @(negedge clk);
      chk("prod_hold", prod8, 'hC080);

      // start held high; operand changes during RUN must be ignored
      a8 = 3; b8 = 5; is8 = 0; s8 = 1; q8.push_back('{15, cyc});
      @(negedge clk);
      a8 = 7; b8 = 9;
      for (int n = 0; n < 20 && !done8; n++) @(negedge clk);
      a8 = 4; b8 = 4; q8.push_back('{16, cyc});
      @(negedge clk);
      s8 = 0; a8 = 9; b8 = 9;
      drain(0);

      // abort mid-RUN: no done pulse may follow
      a8 = 100; b8 = 100; s8 = 1;
      @(negedge clk);
      s8 = 0;
      repeat (3) @(negedge clk);
      chk("busy_before_abort", busy8, 1);
      reset = 1;
      @(negedge clk);
      reset = 0;
      chk("abort busy", busy8, 0);
      chk("abort done", done8, 0);
      chk("abort prod", prod8, 0);
      repeat (15) @(negedge clk);
      issue(0, 100, 100, 0, 10000);
      drain(0);

      for (int s = 0; s < 2; s++)
         for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
               issue(1, a, b, s[0], refp(4, a, b, s[0]));
      drain(1);

      issue(2, 'h8000, 'h8000, 1, refp(16, 'h8000, 'h8000, 1));
      issue(2, 'hFFFF, 'hFFFF, 0, refp(16, 'hFFFF, 'hFFFF, 0));
      for (int i = 0; i < 300; i++) begin
         longint ra, rb;
         bit     rs;
         ra = $urandom_range(0, 65535);
         rb = $urandom_range(0, 65535);
         rs = 1'($urandom_range(0, 1));
         issue(2, ra, rb, rs, refp(16, ra, rb, rs));
      end
      drain(2);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
